// File: rtl/uart_xmit_control_if.sv
// Handshake bundle between the UART transmit sequencer and its neighbours.
// The slave side is the sequencer. The master side is the host and shift-register side.
interface uart_xmit_control_if;
    logic Start;
    logic SerIn;
    logic Load;
    logic Shift;
    logic TxD;
    logic Busy;
    logic Done;

    modport master (
        output Start, SerIn,
        input  Load, Shift, TxD, Busy, Done
    );

    modport slave (
        input  Start, SerIn,
        output Load, Shift, TxD, Busy, Done
    );
endinterface

// File: rtl/uart_xmit_control.sv
// UART transmit sequencer: frames the shift register's serial bit with start/stop bits,
// drives Load/Shift strobes and times every bit with an internal baud counter.
module uart_xmit_control #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    uart_xmit_control_if.slave   bus
);

    localparam int BC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int NB_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(CLKS_PER_BIT - 1);
    localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);
    localparam logic [NB_W-1:0] NB_LAST = NB_W'(DATA_BITS - 1);
    localparam logic [NB_W-1:0] NB_ONE  = NB_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [BC_W-1:0]   bc_q, bc_d;
    logic [NB_W-1:0]   nb_q, nb_d;
    logic              done_q, done_d;
    logic              bit_end_s;
    logic              txd_s;

    assign bit_end_s = (bc_q == BC_LAST);

    // State, counter and Done registers; Reset wins over everything, so an aborted frame never pulses Done.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            bc_q    <= '0;
            nb_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bc_q    <= bc_d;
            nb_q    <= nb_d;
            done_q  <= done_d;
        end
    end

    // Next-state and counter sequencing for one frame.
    always_comb begin
        state_d = state_q;
        bc_d    = bc_q;
        nb_d    = nb_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bc_d = '0;
                if (bus.Start) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d = ST_DATA;
                    bc_d    = '0;
                    nb_d    = '0;
                end else begin
                    bc_d = bc_q + BC_ONE;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    bc_d = '0;
                    if (nb_q == NB_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        nb_d = nb_q + NB_ONE;
                    end
                end else begin
                    bc_d = bc_q + BC_ONE;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    state_d = ST_IDLE;
                    bc_d    = '0;
                    done_d  = 1'b1;
                end else begin
                    bc_d = bc_q + BC_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                bc_d    = '0;
                nb_d    = '0;
            end
        endcase
    end

    // Line level decoded from the state register; DATA passes the shift register's bit 0 through.
    always_comb begin
        txd_s = 1'b1;
        case (state_q)
            ST_IDLE:  txd_s = 1'b1;
            ST_START: txd_s = 1'b0;
            ST_DATA:  txd_s = bus.SerIn;
            ST_STOP:  txd_s = 1'b1;
            default:  txd_s = 1'b1;
        endcase
    end

    // Load is combinational so the byte is captured on the same edge the FSM leaves IDLE.
    assign bus.Load  = (state_q == ST_IDLE) & bus.Start & ~Reset;
    assign bus.Shift = (state_q == ST_DATA) & bit_end_s;
    assign bus.TxD   = txd_s;
    assign bus.Busy  = (state_q != ST_IDLE);
    assign bus.Done  = done_q;

endmodule

// File: tb/tb_uart_xmit_control.sv
// Self-checking bench: three sequencers (4, 2 and 16 clocks per bit), each with its own shift register,
// compared every cycle against a frame-position reference model plus directed corner-case sequences.
module tb_uart_xmit_control;

    localparam int NI = 3;
    localparam int FB = 10;   // bits per frame: start + 8 data + stop

    logic       clk;
    logic       start_s [NI];
    logic       rst_s   [NI];
    logic [7:0] din_s   [NI];
    logic [7:0] sr_q    [NI];
    logic       load_w  [NI];
    logic       shift_w [NI];
    logic       txd_w   [NI];
    logic       busy_w  [NI];
    logic       done_w  [NI];

    int cpb [NI] = '{4, 2, 16};

    int n_checks = 0;
    int n_err    = 0;

    // reference model: position within the frame in clock cycles, -1 when idle
    int         m_pos  [NI];
    logic [7:0] m_data [NI];
    logic       m_done [NI];

    uart_xmit_control_if if0 ();
    uart_xmit_control_if if1 ();
    uart_xmit_control_if if2 ();

    uart_xmit_control #(.CLKS_PER_BIT(4),  .DATA_BITS(8)) dut4  (.Clock(clk), .Reset(rst_s[0]), .bus(if0));
    uart_xmit_control #(.CLKS_PER_BIT(2),  .DATA_BITS(8)) dut2  (.Clock(clk), .Reset(rst_s[1]), .bus(if1));
    uart_xmit_control #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut16 (.Clock(clk), .Reset(rst_s[2]), .bus(if2));

    assign if0.Start = start_s[0];
    assign if1.Start = start_s[1];
    assign if2.Start = start_s[2];
    assign if0.SerIn = sr_q[0][0];
    assign if1.SerIn = sr_q[1][0];
    assign if2.SerIn = sr_q[2][0];

    assign load_w[0]  = if0.Load;   assign load_w[1]  = if1.Load;   assign load_w[2]  = if2.Load;
    assign shift_w[0] = if0.Shift;  assign shift_w[1] = if1.Shift;  assign shift_w[2] = if2.Shift;
    assign txd_w[0]   = if0.TxD;    assign txd_w[1]   = if1.TxD;    assign txd_w[2]   = if2.TxD;
    assign busy_w[0]  = if0.Busy;   assign busy_w[1]  = if1.Busy;   assign busy_w[2]  = if2.Busy;
    assign done_w[0]  = if0.Done;   assign done_w[1]  = if1.Done;   assign done_w[2]  = if2.Done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // right-shifting transmit register, one per sequencer; never reset
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (load_w[k])
                sr_q[k] <= din_s[k];
            else if (shift_w[k])
                sr_q[k] <= {1'b0, sr_q[k][7:1]};
        end
    end

    function automatic logic m_txd(input int k);
        int b;
        if (m_pos[k] < 0) return 1'b1;
        b = m_pos[k] / cpb[k];
        if (b == 0) return 1'b0;
        if (b == FB - 1) return 1'b1;
        return m_data[k][b-1];
    endfunction

    function automatic logic m_shift(input int k);
        int b;
        if (m_pos[k] < 0) return 1'b0;
        b = m_pos[k] / cpb[k];
        return (b >= 1) && (b <= 8) && ((m_pos[k] % cpb[k]) == cpb[k] - 1);
    endfunction

    task automatic chk(input string name, input int k, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst=%0d t=%0t got=%b exp=%b", name, k, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int k, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s inst=%0d t=%0t got=%0d exp=%0d", name, k, $time, act, exp);
        end
    endtask

    task automatic settle_and_check();
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("load",  k, load_w[k],  (m_pos[k] < 0) && start_s[k] && !rst_s[k]);
            chk("shift", k, shift_w[k], m_shift(k));
            chk("txd",   k, txd_w[k],   m_txd(k));
            chk("busy",  k, busy_w[k],  m_pos[k] >= 0);
            chk("done",  k, done_w[k],  m_done[k]);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            if (rst_s[k]) begin
                m_pos[k]  = -1;
                m_done[k] = 1'b0;
            end else if (m_pos[k] < 0) begin
                m_done[k] = 1'b0;
                if (start_s[k]) begin
                    m_pos[k]  = 0;
                    m_data[k] = din_s[k];
                end
            end else begin
                m_pos[k]++;
                m_done[k] = (m_pos[k] == FB * cpb[k]);
                if (m_done[k]) m_pos[k] = -1;
            end
        end
        @(negedge clk);
    endtask

    // one frame on instance k, Start for one cycle at c=0, optional ignored Start pulses at p1/p2
    task automatic check_frame(input int k, input logic [7:0] din, input int p1, input int p2);
        int busy_n, shift_n, done_n, done_at, last_sh, bidx;
        bit gap_ok;
        logic [9:0] bits;
        busy_n = 0; shift_n = 0; done_n = 0; done_at = -1; last_sh = -1; gap_ok = 1'b1; bits = '1;
        for (int c = 0; c < FB * cpb[k] + 4; c++) begin
            rst_s[k] = 1'b0;
            if (c == 0) begin
                start_s[k] = 1'b1; din_s[k] = din;
            end else if (c == p1 || c == p2) begin
                start_s[k] = 1'b1; din_s[k] = 8'h3C;
            end else begin
                start_s[k] = 1'b0;
            end
            settle_and_check();
            if (c == 0)
                chk("load_on_start", k, load_w[k], 1'b1);
            else if (c == p1 || c == p2)
                chk("load_while_busy", k, load_w[k], 1'b0);
            if (busy_w[k]) begin
                bidx = busy_n;
                if ((bidx % cpb[k]) == cpb[k] - 1 && (bidx / cpb[k]) < FB)
                    bits[bidx / cpb[k]] = txd_w[k];
                busy_n++;
            end
            if (shift_w[k]) begin
                if (last_sh >= 0 && (c - last_sh) != cpb[k]) gap_ok = 1'b0;
                last_sh = c;
                shift_n++;
            end
            if (done_w[k]) begin
                done_n++;
                done_at = c;
            end
            advance();
        end
        start_s[k] = 1'b0;
        chk_int("busy_len",    k, busy_n,  FB * cpb[k]);
        chk_int("shift_count", k, shift_n, 8);
        chk("shift_spacing",   k, gap_ok,  1'b1);
        chk_int("done_count",  k, done_n,  1);
        chk_int("done_cycle",  k, done_at, FB * cpb[k] + 1);
        chk_int("frame_bits",  k, int'(bits), int'({1'b1, din, 1'b0}));
    endtask

    typedef struct {
        logic rst;
        logic start;
        logic e_load;
        logic e_txd;
        logic e_busy;
        logic e_done;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int t1, t2, dn;
        bit all1, prev_busy;

        vecs[0] = '{rst: 1'b1, start: 1'b1, e_load: 1'b0, e_txd: 1'b1, e_busy: 1'b0, e_done: 1'b0};
        vecs[1] = '{rst: 1'b1, start: 1'b1, e_load: 1'b0, e_txd: 1'b1, e_busy: 1'b0, e_done: 1'b0};
        vecs[2] = '{rst: 1'b1, start: 1'b1, e_load: 1'b0, e_txd: 1'b1, e_busy: 1'b0, e_done: 1'b0};
        vecs[3] = '{rst: 1'b0, start: 1'b0, e_load: 1'b0, e_txd: 1'b1, e_busy: 1'b0, e_done: 1'b0};
        vecs[4] = '{rst: 1'b0, start: 1'b0, e_load: 1'b0, e_txd: 1'b1, e_busy: 1'b0, e_done: 1'b0};
        vecs[5] = '{rst: 1'b0, start: 1'b0, e_load: 1'b0, e_txd: 1'b1, e_busy: 1'b0, e_done: 1'b0};

        for (int k = 0; k < NI; k++) begin
            m_pos[k] = -1; m_done[k] = 1'b0; m_data[k] = 8'h00;
            rst_s[k] = 1'b1; start_s[k] = 1'b1; din_s[k] = 8'h00;
        end
        advance();

        // reset values, with Start held high during reset and low after release
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < NI; k++) begin
                rst_s[k] = vecs[i].rst; start_s[k] = vecs[i].start;
            end
            settle_and_check();
            chk("tbl_load", 0, load_w[0], vecs[i].e_load);
            chk("tbl_txd",  0, txd_w[0],  vecs[i].e_txd);
            chk("tbl_busy", 0, busy_w[0], vecs[i].e_busy);
            chk("tbl_done", 0, done_w[0], vecs[i].e_done);
            advance();
        end

        // single frame, then the same frame with ignored Start pulses at cycles 5 and 20
        check_frame(0, 8'hA5, -1, -1);
        check_frame(0, 8'hA5, 5, 20);

        // back-to-back frames with Start held high
        t1 = -1; t2 = -1; all1 = 1'b1; prev_busy = 1'b0;
        din_s[0] = 8'h00; start_s[0] = 1'b1;
        for (int c = 0; c < 86; c++) begin
            if (c == 1)  din_s[0] = 8'hFF;
            if (c == 42) start_s[0] = 1'b0;
            settle_and_check();
            if (busy_w[0] && !prev_busy) begin
                if (t1 < 0) t1 = c;
                else if (t2 < 0) t2 = c;
            end
            if (c == 41) begin
                chk("b2b_gap_txd",  0, txd_w[0],  1'b1);
                chk("b2b_gap_done", 0, done_w[0], 1'b1);
                chk("b2b_gap_load", 0, load_w[0], 1'b1);
                chk("b2b_gap_busy", 0, busy_w[0], 1'b0);
            end
            if (c >= 46 && c < 78) all1 = all1 & txd_w[0];
            prev_busy = busy_w[0];
            advance();
        end
        chk_int("b2b_period", 0, t2 - t1, 41);
        chk("b2b_data_ones", 0, all1, 1'b1);

        // reset during data bit 3, then a clean 0x5A frame
        dn = 0;
        din_s[0] = 8'hA5;
        for (int c = 0; c < 60; c++) begin
            start_s[0] = (c == 0);
            rst_s[0]   = (c == 18);
            settle_and_check();
            if (c == 19) begin
                chk("abort_txd",  0, txd_w[0],  1'b1);
                chk("abort_busy", 0, busy_w[0], 1'b0);
                chk("abort_done", 0, done_w[0], 1'b0);
            end
            if (c >= 19 && done_w[0]) dn++;
            advance();
        end
        chk_int("abort_no_done", 0, dn, 0);
        check_frame(0, 8'h5A, -1, -1);

        // other baud settings
        check_frame(1, 8'h81, -1, -1);
        check_frame(2, 8'h81, -1, -1);

        // random traffic on all three sequencers
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NI; k++) begin
                start_s[k] = ($urandom_range(0, 7) == 0);
                rst_s[k]   = ($urandom_range(0, 199) == 0);
                din_s[k]   = 8'($urandom);
            end
            settle_and_check();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
